// File: rtl/matrix_dot_stream.sv
// matrix_dot_stream
//   Streaming unsigned dot-product engine. Each accepted beat carries LANES
//   operand pairs; their products are summed through a three-stage pipeline
//   (S1 products, S2 adder-tree sum, S3 accumulate). The accumulator collects
//   every beat up to and including the one marked in_last. The finished
//   result is then held until the consumer takes it.
//
//   Build option: define MATRIX_DOT_SAT_EN to make the accumulator saturate
//   at 2^ACC_W-1 on overflow. When it is undefined, the accumulator wraps
//   modulo 2^ACC_W. out_ovf is set on overflow in both builds.
//
//   Ports
//     clk        rising-edge clock
//     reset      synchronous, active-high reset
//     in_a       LANES*DW vector operand, lane i at [i*DW +: DW]
//     in_b       LANES*DW matrix-row operand, same packing
//     in_valid   beat present on in_a/in_b/in_last
//     in_last    final beat of the current dot product
//     in_ready   beat accepted when in_valid & in_ready
//     out_sum    completed dot-product result
//     out_beats  beats accumulated, saturating at 255
//     out_ovf    sticky accumulate overflow for this result
//     out_valid  result held on out_sum/out_beats/out_ovf
//     out_ready  consumer accepts the held result
//
//   state | meaning
//   IDLE  | empty, accumulator/count/ovf zero, accepting beats
//   ACCUM | partial dot product in progress, accepting beats
//   DRAIN | last beat accepted, 3 cycles for the pipeline to empty
//   HOLD  | result valid and frozen until out_ready
module matrix_dot_stream #(
   parameter int LANES = 4,
   parameter int DW    = 8,
   parameter int ACC_W = 20
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [LANES*DW-1:0] in_a,
   input  logic [LANES*DW-1:0] in_b,
   input  logic               in_valid,
   input  logic               in_last,
   output logic               in_ready,
   output logic [ACC_W-1:0]   out_sum,
   output logic [7:0]         out_beats,
   output logic               out_ovf,
   output logic               out_valid,
   input  logic               out_ready
);

   localparam int PW = 2 * DW;
   localparam int SW = PW + $clog2(LANES);

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

   state_t            state, state_nxt;
   logic [1:0]        drain_cnt;
   logic              accept;
   logic              release_res;
   logic [PW-1:0]     mult [LANES];
   logic [PW-1:0]     prod [LANES];
   logic              v1, v2;
   logic [SW-1:0]     tree_sum;
   logic [SW-1:0]     s2;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W:0]    acc_ext;
   logic [7:0]        beats;
   logic              ovf;

   assign in_ready    = (state == IDLE) || (state == ACCUM);
   assign out_valid   = (state == HOLD);
   assign accept      = in_valid & in_ready;
   assign release_res = (state == HOLD) & out_ready;

   assign out_sum   = acc;
   assign out_beats = beats;
   assign out_ovf   = ovf;

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         mult[i] = {{DW{1'b0}}, in_a[i*DW +: DW]} * {{DW{1'b0}}, in_b[i*DW +: DW]};
      end
   end

   always_comb begin
      tree_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         tree_sum = tree_sum + {{(SW-PW){1'b0}}, prod[i]};
      end
   end

   // Carry out of the ACC_W-bit add lands in the top bit.
   assign acc_ext = {1'b0, acc} + {{(ACC_W+1-SW){1'b0}}, s2};

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LANES; i++) prod[i] <= '0;
         v1 <= 1'b0;
         v2 <= 1'b0;
         s2 <= '0;
      end else begin
         if (accept) begin
            for (int i = 0; i < LANES; i++) prod[i] <= mult[i];
         end
         v1 <= accept;
         v2 <= v1;
         s2 <= tree_sum;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || release_res) begin
         acc   <= '0;
         ovf   <= 1'b0;
         beats <= '0;
      end else begin
         if (v2) begin
            if (acc_ext[ACC_W]) begin
               ovf <= 1'b1;
`ifdef MATRIX_DOT_SAT_EN
               acc <= '1;
`else
               acc <= acc_ext[ACC_W-1:0];
`endif
            end else begin
               acc <= acc_ext[ACC_W-1:0];
            end
         end
         if (accept && beats != 8'hFF) beats <= beats + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Down-counter: loaded on DRAIN entry, HOLD follows its terminal count,
   // which puts the accumulate of the last beat one edge ahead of HOLD.
   always_ff @(posedge clk) begin
      if (reset)                                   drain_cnt <= '0;
      else if (state != DRAIN && state_nxt == DRAIN) drain_cnt <= 2'd2;
      else if (state == DRAIN && drain_cnt != 2'd0) drain_cnt <= drain_cnt - 2'd1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, ACCUM: begin
            if (accept) state_nxt = in_last ? DRAIN : ACCUM;
         end
         DRAIN: begin
            if (drain_cnt == 2'd0) state_nxt = HOLD;
         end
         HOLD: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_matrix_dot_stream.sv
module tb_matrix_dot_stream;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] in_a, in_b;
   logic        in_valid, in_last;
   logic        in_ready;
   logic [19:0] out_sum;
   logic [7:0]  out_beats;
   logic        out_ovf;
   logic        out_valid;
   logic        out_ready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   matrix_dot_stream #(.LANES(4), .DW(8), .ACC_W(20)) dut (
      .clk(clk), .reset(reset),
      .in_a(in_a), .in_b(in_b), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready),
      .out_sum(out_sum), .out_beats(out_beats), .out_ovf(out_ovf),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [19:0] sum;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Beat is accepted at the posedge between the two negedges.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
      @(negedge clk);
      in_a = a; in_b = b; in_valid = 1'b1; in_last = last;
      check("in_ready_at_beat", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   // Called at the negedge right after the last beat's edge; returns edges waited.
   task automatic wait_result(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic take_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("idle_out_valid", out_valid, 0);
      check("idle_in_ready", in_ready, 1);
      check("idle_sum_cleared", out_sum, 0);
      check("idle_beats_cleared", out_beats, 0);
   endtask

   initial begin
      int lat;
      logic [19:0] ovf_exp;

      vecs[0] = '{32'h04030201, 32'h08070605, 20'd70};
      vecs[1] = '{32'h01010101, 32'h02020202, 20'd8};
      vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 20'd260100};
      vecs[3] = '{32'h00000000, 32'hFFFFFFFF, 20'd0};
      vecs[4] = '{32'h000000FF, 32'h00000002, 20'd510};
      vecs[5] = '{32'h0A000000, 32'h14000000, 20'd200};
      vecs[6] = '{32'h01020304, 32'h08070605, 20'd60};

      in_a = '0; in_b = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      check("rst_out_valid", out_valid, 0);
      check("rst_out_sum", out_sum, 0);
      check("rst_out_beats", out_beats, 0);
      check("rst_out_ovf", out_ovf, 0);
      check("rst_in_ready", in_ready, 1);

      // out_ready with nothing held must not disturb anything
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("stray_ready_in_ready", in_ready, 1);

      // single-beat table
      for (int i = 0; i < 7; i++) begin
         send(vecs[i].a, vecs[i].b, 1'b1);
         check("drain_in_ready", in_ready, 0);
         wait_result(lat);
         check("single_latency", lat, 3);
         check("single_sum", out_sum, vecs[i].sum);
         check("single_beats", out_beats, 1);
         check("single_ovf", out_ovf, 0);
         take_result();
      end

      // three gapped beats
      send(32'h04030201, 32'h08070605, 1'b0);
      send(32'h04030201, 32'h08070605, 1'b0);
      send(32'h04030201, 32'h08070605, 1'b1);
      for (int k = 0; k < 3; k++) begin
         check("multi_drain_in_ready", in_ready, 0);
         @(negedge clk);
      end
      check("multi_valid", out_valid, 1);
      check("multi_sum", out_sum, 210);
      check("multi_beats", out_beats, 3);
      check("multi_ovf", out_ovf, 0);
      check("multi_hold_in_ready", in_ready, 0);
      take_result();

      // overflow: five beats of all-lane 255x255
`ifdef MATRIX_DOT_SAT_EN
      ovf_exp = 20'd1048575;
`else
      ovf_exp = 20'd251924;
`endif
      for (int k = 0; k < 5; k++) send(32'hFFFFFFFF, 32'hFFFFFFFF, k == 4);
      wait_result(lat);
      check("ovf_valid", out_valid, 1);
      check("ovf_sum", out_sum, ovf_exp);
      check("ovf_beats", out_beats, 5);
      check("ovf_flag", out_ovf, 1);
      take_result();
      check("ovf_cleared", out_ovf, 0);

      // long hold with beats offered and ignored
      send(32'h04030201, 32'h08070605, 1'b1);
      wait_result(lat);
      check("hold_valid", out_valid, 1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         in_a = 32'hFFFFFFFF; in_b = 32'hFFFFFFFF; in_valid = 1'b1; in_last = 1'b1;
         check("hold_stable_valid", out_valid, 1);
         check("hold_stable_sum", out_sum, 70);
         check("hold_stable_beats", out_beats, 1);
      end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      check("hold_after_sum", out_sum, 70);
      take_result();
      send(32'h01010101, 32'h02020202, 1'b1);
      wait_result(lat);
      check("after_hold_latency", lat, 3);
      check("after_hold_sum", out_sum, 8);
      check("after_hold_beats", out_beats, 1);
      take_result();

      // reset in DRAIN of a 2-beat job
      send(32'h04030201, 32'h08070605, 1'b0);
      send(32'h04030201, 32'h08070605, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_drain_in_ready", in_ready, 1);
      check("rst_drain_sum", out_sum, 0);
      check("rst_drain_beats", out_beats, 0);
      for (int k = 0; k < 8; k++) begin
         check("rst_drain_no_valid", out_valid, 0);
         @(negedge clk);
      end
      check("rst_drain_sum_later", out_sum, 0);
      send(32'h01010101, 32'h02020202, 1'b1);
      wait_result(lat);
      check("post_rst_latency", lat, 3);
      check("post_rst_sum", out_sum, 8);
      check("post_rst_beats", out_beats, 1);
      check("post_rst_ovf", out_ovf, 0);
      take_result();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/matrix_dot_stream.md
MATRIX_DOT_STREAM -- requirements
Module: matrix_dot_stream

Interface
REQ-001 Parameter LANES, default 4: number of multiplier lanes per beat (power of two, 2..16).
REQ-002 Parameter DW, default 8: unsigned operand width per lane.
REQ-003 Parameter ACC_W, default 20: accumulator/result width (>= 2*DW+log2(LANES)).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_a  input  LANES*DW  vector operand; lane i at bits [i*DW +: DW].
REQ-008 in_b  input  LANES*DW  matrix-row operand, same packing as in_a.
REQ-009 in_valid  input  1  beat present on in_a/in_b/in_last.
REQ-010 in_last  input  1  marks final beat of the current dot product.
REQ-011 in_ready  output  1  block accepts a beat this cycle.
REQ-012 out_sum  output  ACC_W  completed dot-product result.
REQ-013 out_beats  output  8  beats accumulated into out_sum, saturating at 255.
REQ-014 out_ovf  output  1  accumulation overflowed/saturated during this result.
REQ-015 out_valid  output  1  result held on out_sum/out_beats/out_ovf.
REQ-016 out_ready  input  1  consumer accepts result.

Function
REQ-017 Beat accepted iff in_valid & in_ready at a rising edge; otherwise inputs SHALL be ignored.
REQ-018 Pipeline: S1 registers LANES products (2*DW each); S2 registers the adder-tree sum; S3 adds the S2 sum into the accumulator, width ACC_W, unsigned.
REQ-019 FSM states IDLE, ACCUM, DRAIN, HOLD; in_ready=1 only in IDLE and ACCUM.
REQ-020 IDLE: accumulator, beat count and overflow flag zero; accepted beat with in_last=0 -> ACCUM; with in_last=1 -> DRAIN.
REQ-021 ACCUM: accepted beat with in_last=1 -> DRAIN; otherwise stay; no beat -> stay (bubbles allowed).
REQ-022 DRAIN: lasts exactly 3 cycles, then -> HOLD; last beat accepted at edge T gives out_valid=1 after edge T+3.
REQ-023 HOLD: out_valid=1, outputs stable; at edge with out_ready=1 -> IDLE, out_valid=0 and in_ready=1 next cycle.
REQ-024 out_ready while out_valid=0 SHALL have no effect.
REQ-025 Beat counter increments per accepted beat, saturating at 255.
REQ-026 Overflow: carry out of the ACC_W-bit accumulate sets the sticky out_ovf until the result is accepted; without saturation the sum wraps modulo 2^ACC_W.
REQ-027 Results SHALL be independent: accumulator, count and ovf cleared on HOLD->IDLE.

Reset
REQ-028 reset SHALL force IDLE, clear all pipeline registers and the accumulator, and drive out_valid=0, out_sum=0, out_beats=0, out_ovf=0, in_ready=1 from the next cycle.
REQ-029 Reset asserted mid-ACCUM/DRAIN/HOLD SHALL discard the partial or held result; no out_valid for it afterwards.

Configuration
REQ-030 Macro MATRIX_DOT_SAT_EN defined: accumulator saturates at 2^ACC_W-1 on overflow, out_ovf=1.
REQ-031 Macro MATRIX_DOT_SAT_EN undefined: accumulator wraps modulo 2^ACC_W, out_ovf=1; all else identical.

Verification (LANES=4, DW=8, ACC_W=20)
REQ-032 Single beat a=(1,2,3,4), b=(5,6,7,8), last=1 at edge T -> out_valid after T+3, out_sum=70, out_beats=1, out_ovf=0.
REQ-033 Three beats with that data, in_valid gapped by 1 idle cycle, last on third -> out_sum=210, out_beats=3; in_ready=0 from DRAIN until accept.
REQ-034 Five beats all lanes 255x255, last on fifth -> out_ovf=1; out_sum=251924 without MATRIX_DOT_SAT_EN, 1048575 with it.
REQ-035 out_ready held 0 for 10 cycles in HOLD -> outputs stable, in_valid beats ignored; out_ready=1 -> IDLE next cycle, new result independent (starts from 0).
REQ-036 Reset asserted during DRAIN of a 2-beat job -> no out_valid; following single beat (1,1,1,1)x(2,2,2,2) -> out_sum=8, out_beats=1.
